// File: rtl/rs_sched_queue.sv
// ============================================================================
// Module   : rs_sched_queue
// Purpose  : Per-FU reservation-station queue. It takes dispatch packets and
//            holds each one until every bit of its dependency mask has been
//            cleared by wakeup broadcasts. It then issues the oldest ready
//            entry to its functional unit with a valid/ready handshake.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            flush_i             - synchronous invalidate of all entries
//            disp_valid_i/_ready_o, disp_pkt_i, disp_dep_mask_i, disp_slot_o
//                                - dispatch side; disp_slot_o is the slot a
//                                  dispatch in this cycle fills
//            wk_valid_i, wk_slot_i - per-FU wakeup of one local slot
//                                  (FU0 in the LSBs)
//            iss_valid_o/iss_ready_i, iss_pkt_o, iss_slot_o - issue side
//            occupancy_o         - number of valid entries
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [5:0]  rob_tag;
    } disp_packet_t;

    localparam int unsigned C_PKT_W = $bits(disp_packet_t);
endpackage

module rs_sched_queue #(
    parameter int unsigned RS_ENTRIES = 8,
    parameter int unsigned NUM_FUS    = 2,
    parameter int unsigned FU_ID      = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic                                 disp_valid_i,
    output logic                                 disp_ready_o,
    input  logic [core_pkg::C_PKT_W-1:0]         disp_pkt_i,
    input  logic [RS_ENTRIES*NUM_FUS-1:0]        disp_dep_mask_i,
    output logic [$clog2(RS_ENTRIES)-1:0]        disp_slot_o,
    input  logic [NUM_FUS-1:0]                   wk_valid_i,
    input  logic [NUM_FUS*$clog2(RS_ENTRIES)-1:0] wk_slot_i,
    output logic                                 iss_valid_o,
    input  logic                                 iss_ready_i,
    output logic [core_pkg::C_PKT_W-1:0]         iss_pkt_o,
    output logic [$clog2(RS_ENTRIES)-1:0]        iss_slot_o,
    output logic [$clog2(RS_ENTRIES):0]          occupancy_o
);

    localparam int unsigned c_IDX_W = $clog2(RS_ENTRIES);
    localparam int unsigned c_GLB_W = RS_ENTRIES * NUM_FUS;
    localparam int unsigned c_PKT_W = core_pkg::C_PKT_W;
    localparam logic [c_IDX_W:0] c_OCC_ONE = {{c_IDX_W{1'b0}}, 1'b1};

    // Elaboration-time parameter sanity checks.
    if (RS_ENTRIES < 2 || (RS_ENTRIES & (RS_ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("rs_sched_queue: RS_ENTRIES must be a power of two >= 2");
    end
    if (FU_ID >= NUM_FUS) begin : g_bad_fu_id
        $error("rs_sched_queue: FU_ID must be below NUM_FUS");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [RS_ENTRIES-1:0] valid_q, valid_d;
    logic [c_PKT_W-1:0]    pkt_q  [RS_ENTRIES];
    logic [c_PKT_W-1:0]    pkt_d  [RS_ENTRIES];
    logic [c_GLB_W-1:0]    mask_q [RS_ENTRIES];
    logic [c_GLB_W-1:0]    mask_d [RS_ENTRIES];
    // age_q[i][j] = 1 means slot i is older than slot j.
    logic [RS_ENTRIES-1:0] age_q  [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] age_d  [RS_ENTRIES];
    logic [c_IDX_W:0]      occ_q, occ_d;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [c_GLB_W-1:0]    w_wake_clr;
    logic                  w_any_free;
    logic [c_IDX_W-1:0]    w_free_slot;
    logic [RS_ENTRIES-1:0] w_ready;
    logic [RS_ENTRIES-1:0] w_sel_oh;
    logic [c_IDX_W-1:0]    w_sel_slot;
    logic [c_PKT_W-1:0]    w_sel_pkt;
    logic                  w_disp_fire;
    logic                  w_iss_fire;

    // Global dependency bits cleared by this cycle's wakeups.
    always_comb begin
        w_wake_clr = '0;
        for (int f = 0; f < int'(NUM_FUS); f++) begin
            if (wk_valid_i[f]) begin
                w_wake_clr[f * int'(RS_ENTRIES) + int'(wk_slot_i[f*c_IDX_W +: c_IDX_W])] = 1'b1;
            end
        end
    end

    // Lowest-index free slot; scanning downwards leaves the lowest one last.
    always_comb begin
        w_free_slot = '0;
        for (int i = int'(RS_ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_free_slot = c_IDX_W'(i);
            end
        end
    end

    assign w_any_free = ~&valid_q;

    // Readiness uses only the registered mask, so a wakeup takes effect
    // one cycle after its edge.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            w_ready[i] = valid_q[i] && (mask_q[i] == '0);
        end
    end

    // An entry wins when no other ready entry is older than it. The age
    // matrix is a total order over valid entries, so at most one bit is set.
    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            w_sel_oh[i] = w_ready[i];
            for (int j = 0; j < int'(RS_ENTRIES); j++) begin
                if (j != i && w_ready[j] && age_q[j][i]) begin
                    w_sel_oh[i] = 1'b0;
                end
            end
        end
    end

    // One-hot to slot/packet via OR-reduction; both are zero when idle.
    always_comb begin
        w_sel_slot = '0;
        w_sel_pkt  = '0;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            if (w_sel_oh[i]) begin
                w_sel_slot = w_sel_slot | c_IDX_W'(i);
                w_sel_pkt  = w_sel_pkt | pkt_q[i];
            end
        end
    end

    assign w_disp_fire = disp_valid_i && w_any_free;
    assign w_iss_fire  = (|w_ready) && iss_ready_i;

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        occ_d   = occ_q;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            pkt_d[i]  = pkt_q[i];
            mask_d[i] = mask_q[i] & ~w_wake_clr;
            age_d[i]  = age_q[i];
        end

        if (w_iss_fire) begin
            valid_d = valid_d & ~w_sel_oh;
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                if (w_sel_oh[i]) begin
                    age_d[i] = '0;
                end
                age_d[i] = age_d[i] & ~w_sel_oh;
            end
        end

        if (w_disp_fire) begin
            valid_d[w_free_slot] = 1'b1;
            pkt_d[w_free_slot]   = disp_pkt_i;
            // Same-cycle wakeups also apply to the incoming mask.
            mask_d[w_free_slot]  = disp_dep_mask_i & ~w_wake_clr;
            // Every entry that survives this edge is older than the new one.
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                age_d[i][w_free_slot] = valid_q[i] && !(w_iss_fire && w_sel_oh[i]);
            end
            age_d[w_free_slot] = '0;
        end

        if (w_disp_fire && !w_iss_fire) begin
            occ_d = occ_q + c_OCC_ONE;
        end else if (!w_disp_fire && w_iss_fire) begin
            occ_d = occ_q - c_OCC_ONE;
        end

        if (flush_i) begin
            valid_d = '0;
            occ_d   = '0;
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                mask_d[i] = '0;
                age_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                pkt_q[i]  <= '0;
                mask_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                pkt_q[i]  <= pkt_d[i];
                mask_q[i] <= mask_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign disp_ready_o = w_any_free;
    assign disp_slot_o  = w_free_slot;
    assign iss_valid_o  = |w_ready;
    assign iss_slot_o   = w_sel_slot;
    assign iss_pkt_o    = w_sel_pkt;
    assign occupancy_o  = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_sched_queue.sv
// ============================================================================
// Module   : tb_rs_sched_queue
// Purpose  : Self-checking bench for rs_sched_queue. Directed scenarios
//            followed by a random phase, all compared against a reference
//            model that tracks entries with dispatch sequence numbers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_sched_queue;

    localparam int N     = 8;
    localparam int F     = 2;
    localparam int IW    = 3;
    localparam int G     = N * F;
    localparam int PKT_W = core_pkg::C_PKT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush_i = 1'b0;
    logic             disp_valid_i = 1'b0;
    logic             disp_ready_o;
    logic [PKT_W-1:0] disp_pkt_i = '0;
    logic [G-1:0]     disp_dep_mask_i = '0;
    logic [IW-1:0]    disp_slot_o;
    logic [F-1:0]     wk_valid_i = '0;
    logic [F*IW-1:0]  wk_slot_i = '0;
    logic             iss_valid_o;
    logic             iss_ready_i = 1'b0;
    logic [PKT_W-1:0] iss_pkt_o;
    logic [IW-1:0]    iss_slot_o;
    logic [IW:0]      occupancy_o;

    rs_sched_queue #(.RS_ENTRIES(N), .NUM_FUS(F), .FU_ID(0)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_pkt_i      (disp_pkt_i),
        .disp_dep_mask_i (disp_dep_mask_i),
        .disp_slot_o     (disp_slot_o),
        .wk_valid_i      (wk_valid_i),
        .wk_slot_i       (wk_slot_i),
        .iss_valid_o     (iss_valid_o),
        .iss_ready_i     (iss_ready_i),
        .iss_pkt_o       (iss_pkt_o),
        .iss_slot_o      (iss_slot_o),
        .occupancy_o     (occupancy_o)
    );

    always #5 clk = ~clk;

    // Reference model: entries with dispatch sequence numbers; oldest = smallest.
    logic             m_valid [N];
    logic [PKT_W-1:0] m_pkt   [N];
    logic [G-1:0]     m_mask  [N];
    int               m_seq   [N];
    int               seq_ctr = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_lowest_free();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int m_oldest_ready();
        int best = -1;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_mask[i] == '0 && (best < 0 || m_seq[i] < m_seq[best])) best = i;
        end
        return best;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic logic [PKT_W-1:0] rand_pkt();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PKT_W-1:0];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_mask[i]  = '0;
            m_pkt[i]   = '0;
            m_seq[i]   = 0;
        end
    endtask

    task automatic check_all(input string tag);
        int fr  = m_lowest_free();
        int sel = m_oldest_ready();
        chk({tag, ":disp_ready"}, 64'(disp_ready_o), 64'(fr >= 0));
        if (fr >= 0) chk({tag, ":disp_slot"}, 64'(disp_slot_o), 64'(fr));
        chk({tag, ":iss_valid"}, 64'(iss_valid_o), 64'(sel >= 0));
        chk({tag, ":iss_slot"}, 64'(iss_slot_o), 64'((sel >= 0) ? sel : 0));
        chk({tag, ":iss_pkt"}, 64'(iss_pkt_o), 64'((sel >= 0) ? m_pkt[sel] : '0));
        chk({tag, ":occupancy"}, 64'(occupancy_o), 64'(m_count()));
    endtask

    // Apply the current inputs to the model as the coming edge will.
    task automatic m_update();
        int fr  = m_lowest_free();
        int sel = m_oldest_ready();
        logic [G-1:0] clr = '0;
        if (flush_i) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_mask[i]  = '0;
            end
            return;
        end
        for (int f = 0; f < F; f++) if (wk_valid_i[f]) clr[f*N + int'(wk_slot_i[f*IW +: IW])] = 1'b1;
        for (int i = 0; i < N; i++) m_mask[i] = m_mask[i] & ~clr;
        if (sel >= 0 && iss_ready_i) m_valid[sel] = 1'b0;
        if (disp_valid_i && fr >= 0) begin
            m_valid[fr] = 1'b1;
            m_pkt[fr]   = disp_pkt_i;
            m_mask[fr]  = disp_dep_mask_i & ~clr;
            m_seq[fr]   = seq_ctr++;
        end
    endtask

    task automatic set_in(input logic dv, input logic [G-1:0] dep, input logic [F-1:0] wv,
                          input logic [F*IW-1:0] ws, input logic ir, input logic fl);
        disp_valid_i    = dv;
        disp_pkt_i      = rand_pkt();
        disp_dep_mask_i = dep;
        wk_valid_i      = wv;
        wk_slot_i       = ws;
        iss_ready_i     = ir;
        flush_i         = fl;
    endtask

    // Called in the low phase with inputs already set.
    task automatic step(input string tag);
        #1;
        check_all(tag);
        m_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        m_clear();
        @(negedge clk);
        #1;
        chk("rst:disp_ready", 64'(disp_ready_o), 64'(1));
        chk("rst:disp_slot", 64'(disp_slot_o), 64'(0));
        chk("rst:iss_valid", 64'(iss_valid_o), 64'(0));
        chk("rst:iss_slot", 64'(iss_slot_o), 64'(0));
        chk("rst:iss_pkt", 64'(iss_pkt_o), 64'(0));
        chk("rst:occupancy", 64'(occupancy_o), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // T1: single ADDI, no dependencies.
        set_in(1'b1, '0, '0, '0, 1'b1, 1'b0);
        disp_pkt_i[PKT_W-1 -: 7] = 7'h13;
        step("T1a");
        set_in(1'b0, '0, '0, '0, 1'b1, 1'b0);
        #1;
        chk("T1:iss_valid", 64'(iss_valid_o), 64'(1));
        chk("T1:iss_slot", 64'(iss_slot_o), 64'(0));
        chk("T1:occ1", 64'(occupancy_o), 64'(1));
        step("T1b");
        chk("T1:occ0", 64'(occupancy_o), 64'(0));

        // T2: fill with dependency on global slot 9 (FU1 slot 1).
        for (int k = 0; k < N; k++) begin
            set_in(1'b1, G'(1) << 9, '0, '0, 1'b1, 1'b0);
            step("T2fill");
        end
        set_in(1'b1, '0, '0, '0, 1'b1, 1'b0);
        #1;
        chk("T2:full_ready", 64'(disp_ready_o), 64'(0));
        chk("T2:full_issv", 64'(iss_valid_o), 64'(0));
        step("T2ninth");
        set_in(1'b0, '0, 2'b10, {3'd1, 3'd0}, 1'b0, 1'b0);
        step("T2wake");
        for (int k = 0; k < N; k++) begin
            set_in(1'b0, '0, '0, '0, 1'b1, 1'b0);
            #1;
            chk("T2:order", 64'(iss_slot_o), 64'(k));
            step("T2drain");
        end

        // T3: older entry becomes ready after a younger one is presented.
        set_in(1'b1, G'(1) << 3, '0, '0, 1'b0, 1'b0);
        step("T3a");
        set_in(1'b1, '0, '0, '0, 1'b0, 1'b0);
        step("T3b");
        set_in(1'b0, '0, 2'b01, {3'd0, 3'd3}, 1'b0, 1'b0);
        #1;
        chk("T3:young_first", 64'(iss_slot_o), 64'(1));
        step("T3wake");
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("T3:old_next", 64'(iss_slot_o), 64'(0));
        step("T3c");
        set_in(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step("T3d");
        step("T3e");

        // T4: wakeup coincident with dispatch is not lost.
        set_in(1'b1, G'(1) << 2, 2'b01, {3'd0, 3'd2}, 1'b0, 1'b0);
        step("T4a");
        set_in(1'b0, '0, '0, '0, 1'b1, 1'b0);
        #1;
        chk("T4:ready", 64'(iss_valid_o), 64'(1));
        step("T4b");

        // T5: full queue, issue and dispatch offered together.
        for (int k = 0; k < N; k++) begin
            set_in(1'b1, '0, '0, '0, 1'b0, 1'b0);
            step("T5fill");
        end
        set_in(1'b1, '0, '0, '0, 1'b1, 1'b0);
        #1;
        chk("T5:stall", 64'(disp_ready_o), 64'(0));
        step("T5a");
        set_in(1'b1, '0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("T5:reuse_slot", 64'(disp_slot_o), 64'(0));
        step("T5b");
        chk("T5:occ_full", 64'(occupancy_o), 64'(8));

        // T6: flush with concurrent dispatch, then async reset mid-cycle.
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step("T6clr");
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, G'($urandom_range(0, 1)) << 12, '0, '0, 1'b0, 1'b0);
            step("T6fill");
        end
        set_in(1'b1, '0, 2'b11, 6'($urandom()), 1'b1, 1'b1);
        step("T6flush");
        chk("T6:occ", 64'(occupancy_o), 64'(0));
        chk("T6:issv", 64'(iss_valid_o), 64'(0));
        chk("T6:slot", 64'(disp_slot_o), 64'(0));
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, '0, '0, '0, 1'b0, 1'b0);
            step("T6refill");
        end
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        m_clear();
        chk("T6:arst_occ", 64'(occupancy_o), 64'(0));
        chk("T6:arst_issv", 64'(iss_valid_o), 64'(0));
        chk("T6:arst_ready", 64'(disp_ready_o), 64'(1));
        #1;
        rst = 1'b0;
        @(negedge clk);

        // Random phase.
        for (int c = 0; c < 600; c++) begin
            set_in($urandom_range(0, 3) != 0,
                   G'($urandom() & $urandom() & $urandom()),
                   F'($urandom()), (F*IW)'($urandom()),
                   $urandom_range(0, 2) != 0,
                   $urandom_range(0, 63) == 0);
            step("rand");
        end
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
